// File: rtl/bp_clint_pkg.sv
// Shared CLINT definitions: address-map offsets, response record, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package bp_clint_pkg;

    // Device id carried in address bits [23:20]
    localparam logic [3:0]  clint_dev_gp             = 4'd3;

    // Register-block offsets inside the CLINT device window
    localparam logic [19:0] clint_mipi_offset_gp     = 20'h0_0000;
    localparam logic [19:0] clint_mtimecmp_offset_gp = 20'h0_4000;
    localparam logic [19:0] clint_mtime_offset_gp    = 20'h0_8000;
    localparam logic [19:0] clint_plic_offset_gp     = 20'h0_B000;

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } bp_clint_resp_s;

    typedef enum logic [0:0] {
        e_clint_idle = 1'b0,
        e_clint_resp = 1'b1
    } bp_clint_state_e;

    // Doubleword slot of an address relative to a block base. Addresses below
    // the base wrap to a huge value, so a single "< num_core" test covers both ends.
    function automatic logic [16:0] clint_slot(input logic [16:0] word, input logic [16:0] base_word);
        return word - base_word;
    endfunction

endpackage

// File: rtl/bp_clint_mtime_counter.sv
// Shared mtime: prescaler dividing core_clk by timebase_div_p feeding a 64-bit counter.
// Latency: a write or tick is visible on mtime_o the following cycle.
// Backpressure: none; a write in a tick cycle wins and that tick is dropped.
module bp_clint_mtime_counter #(
    parameter int timebase_div_p = 8
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        we_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] mtime_o,
    output logic        tick_o
);

    localparam int pw_lp = (timebase_div_p > 1) ? $clog2(timebase_div_p) : 1;
    localparam logic [pw_lp-1:0] last_lp = pw_lp'(timebase_div_p - 1);

    logic [pw_lp-1:0] prescale_q, prescale_d;
    logic [63:0]      mtime_q, mtime_d;

    // Prescaler keeps running through software writes; the counter prefers the write.
    always_comb begin
        tick_o     = (prescale_q == last_lp);
        prescale_d = tick_o ? '0 : prescale_q + pw_lp'(1);
        mtime_d    = mtime_q;
        if (we_i) begin
            mtime_d = wdata_i;
        end else if (tick_o) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Timebase state
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            prescale_q <= '0;
            mtime_q    <= '0;
        end else begin
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

// File: rtl/bp_clint_ctrl.sv
// CLINT controller: one MMIO request at a time, owns mtime/mtimecmp/mipi/plic and irq lines.
// Latency: response valid the cycle after the request handshake; irq outputs are registered.
// Backpressure: req_ready_o drops while a response is held; response waits for resp_yumi_i.
module bp_clint_ctrl
    import bp_clint_pkg::*;
#(
    parameter int num_core_p     = 4,
    parameter int paddr_width_p  = 40,
    parameter int data_width_p   = 64,
    parameter int timebase_div_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [1:0]               req_size_i,
    input  logic [data_width_p-1:0]  req_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [data_width_p-1:0]  resp_data_o,
    output logic                     resp_err_o,
    output logic [num_core_p-1:0]    soft_irq_o,
    output logic [num_core_p-1:0]    timer_irq_o,
    output logic [num_core_p-1:0]    ext_irq_o
);

    localparam int cw_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    bp_clint_state_e state_q, state_d;
    bp_clint_resp_s  resp_q, resp_d;

    logic [63:0]           mtimecmp_q [num_core_p];
    logic [63:0]           mtimecmp_d [num_core_p];
    logic [num_core_p-1:0] mipi_q, mipi_d;
    logic [num_core_p-1:0] plic_q, plic_d;
    logic [num_core_p-1:0] timer_irq_q, timer_irq_d;

    logic [63:0] mtime;
    logic        mtime_tick_unused;
    logic        mtime_we;

    logic [16:0] word, mipi_slot, cmp_slot, plic_slot;
    logic        dev_hit, size_ok, size8;
    logic        mipi_hit, cmp_hit, mtime_hit, plic_hit, acc_ok, hs, wr_ok;
    logic [63:0] sel_val, rd_data, wval;

    assign req_ready_o = (state_q == e_clint_idle);
    assign resp_v_o    = (state_q == e_clint_resp);
    assign resp_data_o = resp_q.data;
    assign resp_err_o  = resp_q.err;
    assign soft_irq_o  = mipi_q;
    assign ext_irq_o   = plic_q;
    assign timer_irq_o = timer_irq_q;

    bp_clint_mtime_counter #(
        .timebase_div_p(timebase_div_p)
    ) u_mtime (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .we_i     (mtime_we),
        .wdata_i  (wval),
        .mtime_o  (mtime),
        .tick_o   (mtime_tick_unused)
    );

    // Address decode, read mux, half-word merge and register next-state
    always_comb begin
        word      = req_addr_i[19:3];
        dev_hit   = (req_addr_i[paddr_width_p-1:24] == '0) && (req_addr_i[23:20] == clint_dev_gp);
        size8     = (req_size_i == 2'd3);
        size_ok   = size8 ? (req_addr_i[2:0] == 3'b000)
                  : (req_size_i == 2'd2) ? (req_addr_i[1:0] == 2'b00) : 1'b0;
        mipi_slot = clint_slot(word, clint_mipi_offset_gp[19:3]);
        cmp_slot  = clint_slot(word, clint_mtimecmp_offset_gp[19:3]);
        plic_slot = clint_slot(word, clint_plic_offset_gp[19:3]);
        mipi_hit  = mipi_slot < 17'(num_core_p);
        cmp_hit   = cmp_slot  < 17'(num_core_p);
        plic_hit  = plic_slot < 17'(num_core_p);
        mtime_hit = (word == clint_mtime_offset_gp[19:3]);
        acc_ok    = dev_hit && size_ok && (mipi_hit || cmp_hit || mtime_hit || plic_hit);
        hs        = req_v_i && req_ready_o;
        wr_ok     = hs && req_we_i && acc_ok;

        sel_val = '0;
        if (mipi_hit) begin
            sel_val = {63'b0, mipi_q[mipi_slot[cw_lp-1:0]]};
        end else if (cmp_hit) begin
            sel_val = mtimecmp_q[cmp_slot[cw_lp-1:0]];
        end else if (mtime_hit) begin
            sel_val = mtime;
        end else if (plic_hit) begin
            sel_val = {63'b0, plic_q[plic_slot[cw_lp-1:0]]};
        end

        rd_data = size8 ? sel_val
                : {32'b0, (req_addr_i[2] ? sel_val[63:32] : sel_val[31:0])};
        wval    = size8 ? req_data_i
                : (req_addr_i[2] ? {req_data_i[31:0], sel_val[31:0]}
                                 : {sel_val[63:32], req_data_i[31:0]});

        mtime_we = wr_ok && mtime_hit;
        for (int i = 0; i < num_core_p; i++) begin
            mipi_d[i]     = (wr_ok && mipi_hit && (mipi_slot == 17'(i))) ? wval[0] : mipi_q[i];
            plic_d[i]     = (wr_ok && plic_hit && (plic_slot == 17'(i))) ? wval[0] : plic_q[i];
            mtimecmp_d[i] = (wr_ok && cmp_hit && (cmp_slot == 17'(i))) ? wval : mtimecmp_q[i];
            timer_irq_d[i] = (mtime >= mtimecmp_q[i]);
        end
    end

    // Request/response sequencing: capture the response on handshake, hold until yumi
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        case (state_q)
            e_clint_idle: begin
                if (req_v_i) begin
                    state_d     = e_clint_resp;
                    resp_d.err  = ~acc_ok;
                    resp_d.data = (acc_ok && !req_we_i) ? rd_data : '0;
                end
            end
            e_clint_resp: begin
                if (resp_yumi_i) begin
                    state_d = e_clint_idle;
                end
            end
            default: state_d = e_clint_idle;
        endcase
    end

    // FSM and response registers; reset drops any pending response
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_clint_idle;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    // Per-core registers and registered interrupt lines
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_core_p; i++) begin
                mtimecmp_q[i] <= '1;
            end
            mipi_q      <= '0;
            plic_q      <= '0;
            timer_irq_q <= '0;
        end else begin
            for (int i = 0; i < num_core_p; i++) begin
                mtimecmp_q[i] <= mtimecmp_d[i];
            end
            mipi_q      <= mipi_d;
            plic_q      <= plic_d;
            timer_irq_q <= timer_irq_d;
        end
    end

endmodule

// File: tb/tb_bp_clint_ctrl.sv
// Bench for bp_clint_ctrl: directed scenarios plus random traffic against an address-map model.
// Latency: n/a.
// Backpressure: the bench holds resp_yumi low for random stretches.
module tb_bp_clint_ctrl;

    localparam int NC  = 4;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_v = 1'b0, req_we = 1'b0, resp_yumi = 1'b0;
    logic [39:0] req_addr = '0;
    logic [1:0]  req_size = 2'd3;
    logic [63:0] req_data = '0;
    logic        req_ready, resp_v, resp_err;
    logic [63:0] resp_data;
    logic [NC-1:0] soft_irq, timer_irq, ext_irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bp_clint_ctrl #(
        .num_core_p(NC), .paddr_width_p(40), .data_width_p(64), .timebase_div_p(DIV)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(req_v), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_data_i(req_data),
        .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data), .resp_err_o(resp_err),
        .soft_irq_o(soft_irq), .timer_irq_o(timer_irq), .ext_irq_o(ext_irq)
    );

    // ---------------- reference model ----------------
    bit          m_busy;
    int          m_ph;
    logic [63:0] m_mtime;
    logic [63:0] m_cmp [NC];
    logic [NC-1:0] m_mipi, m_plic, e_timer;
    logic [63:0] e_data;
    logic        e_err;

    always @(posedge clk) begin
        logic [NC-1:0]   t_n;
        logic [63:0]     nxt, cur, wv;
        longint unsigned off;
        int              kind, idx;
        bit              ok, tick;
        if (!rst_n) begin
            m_busy = 0; m_ph = 0; m_mtime = 0; m_mipi = 0; m_plic = 0;
            for (int i = 0; i < NC; i++) m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            e_timer = 0; e_data = 0; e_err = 0;
        end else begin
            for (int i = 0; i < NC; i++) t_n[i] = (m_mtime >= m_cmp[i]);
            tick = (m_ph == DIV - 1);
            m_ph = tick ? 0 : m_ph + 1;
            nxt  = tick ? m_mtime + 1 : m_mtime;
            if (!m_busy && req_v) begin
                kind = 0; idx = 0; cur = 0; off = 0;
                if (req_addr >= 40'h30_0000 && req_addr < 40'h40_0000) begin
                    off = longint'(req_addr - 40'h30_0000);
                    if (off < 8 * NC) begin
                        kind = 1; idx = int'(off / 8); cur = {63'b0, m_mipi[idx]};
                    end else if (off >= 16384 && off < 16384 + 8 * NC) begin
                        kind = 2; idx = int'((off - 16384) / 8); cur = m_cmp[idx];
                    end else if (off >= 32768 && off < 32776) begin
                        kind = 3; cur = m_mtime;
                    end else if (off >= 45056 && off < 45056 + 8 * NC) begin
                        kind = 4; idx = int'((off - 45056) / 8); cur = {63'b0, m_plic[idx]};
                    end
                end
                ok = (kind != 0) && (req_size >= 2) && ((off % (64'd1 << req_size)) == 0);
                e_err  = !ok;
                e_data = 0;
                if (ok && !req_we) begin
                    if (req_size == 3) e_data = cur;
                    else if (off % 8 >= 4) e_data = cur >> 32;
                    else e_data = cur & 64'hFFFF_FFFF;
                end
                if (ok && req_we) begin
                    if (req_size == 3) wv = req_data;
                    else if (off % 8 >= 4) wv = {req_data[31:0], cur[31:0]};
                    else wv = {cur[63:32], req_data[31:0]};
                    case (kind)
                        1: m_mipi[idx] = wv[0];
                        2: m_cmp[idx]  = wv;
                        3: nxt         = wv;
                        default: m_plic[idx] = wv[0];
                    endcase
                end
                m_busy = 1;
            end else if (m_busy && resp_yumi) begin
                m_busy = 0;
            end
            m_mtime = nxt;
            e_timer = t_n;
        end
    end

    // ---------------- drivers (no checking) ----------------
    task automatic issue(input logic we, input logic [39:0] a, input logic [1:0] sz, input logic [63:0] d);
        req_v = 1; req_we = we; req_addr = a; req_size = sz; req_data = d;
        @(negedge clk);
        req_v = 0;
    endtask

    task automatic consume(input int hold);
        repeat (hold) @(negedge clk);
        resp_yumi = 1;
        @(negedge clk);
        resp_yumi = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({resp_v, resp_err, req_ready} !== 3'b001) begin
            n_bad++; $display("FAIL reset_ctrl: got v/err/rdy=%b required 001", {resp_v, resp_err, req_ready});
        end
        n_cmp++;
        if (resp_data !== 64'd0) begin
            n_bad++; $display("FAIL reset_data: got %h required 0", resp_data);
        end
        n_cmp++;
        if ({soft_irq, timer_irq, ext_irq} !== '0) begin
            n_bad++; $display("FAIL reset_irq: got %b required 0", {soft_irq, timer_irq, ext_irq});
        end
        rst_n = 1;
    endtask

    task automatic test_idle_mtime;
        repeat (16) @(negedge clk);
        issue(0, 40'h30_8000, 3, 0);
        n_cmp++;
        if (resp_v !== 1 || resp_err !== 0 || resp_data !== 64'd2 || e_data !== 64'd2) begin
            n_bad++; $display("FAIL idle_mtime: got v=%b err=%b data=%0d required v=1 err=0 data=2", resp_v, resp_err, resp_data);
        end
        n_cmp++;
        if ({soft_irq, timer_irq, ext_irq} !== '0) begin
            n_bad++; $display("FAIL idle_irq: got %b required 0", {soft_irq, timer_irq, ext_irq});
        end
        consume(0);
    endtask

    task automatic test_timer;
        bit seen = 0;
        issue(1, 40'h30_4008, 3, 64'd5);
        consume(0);
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            n_cmp++;
            if (timer_irq !== e_timer) begin
                n_bad++; $display("FAIL timer_track: got %b required %b", timer_irq, e_timer);
            end
            if (m_mtime == 64'd5) seen = 1;
        end
        n_cmp++;
        if (!seen || timer_irq !== 4'b0000) begin
            n_bad++; $display("FAIL timer_pre: got %b required 0000 (reached=%0d)", timer_irq, seen);
        end
        @(negedge clk);
        n_cmp++;
        if (timer_irq !== 4'b0010) begin
            n_bad++; $display("FAIL timer_assert: got %b required 0010", timer_irq);
        end
        issue(1, 40'h30_4008, 3, 64'd100);
        n_cmp++;
        if (timer_irq !== 4'b0010) begin
            n_bad++; $display("FAIL timer_hold: got %b required 0010", timer_irq);
        end
        consume(0);
        n_cmp++;
        if (timer_irq !== 4'b0000) begin
            n_bad++; $display("FAIL timer_clear: got %b required 0000", timer_irq);
        end
    endtask

    task automatic test_soft_ext;
        issue(1, 40'h30_0010, 3, 64'd1);
        n_cmp++;
        if (soft_irq !== 4'b0100 || soft_irq !== m_mipi) begin
            n_bad++; $display("FAIL soft_irq: got %b required 0100", soft_irq);
        end
        consume(0);
        issue(1, 40'h30_B018, 3, 64'd1);
        n_cmp++;
        if (ext_irq !== 4'b1000 || ext_irq !== m_plic) begin
            n_bad++; $display("FAIL ext_irq: got %b required 1000", ext_irq);
        end
        consume(0);
        issue(0, 40'h30_0010, 3, 0);
        n_cmp++;
        if (resp_data !== 64'd1 || resp_err !== 0) begin
            n_bad++; $display("FAIL mipi_readback: got data=%h err=%b required 1/0", resp_data, resp_err);
        end
        consume(0);
    endtask

    task automatic test_write_over_tick;
        for (int c = 0; c < 2 * DIV && m_ph != DIV - 1; c++) @(negedge clk);
        issue(1, 40'h30_8000, 3, 64'hFFFF_FFFF_FFFF_FFFF);
        consume(0);
        issue(0, 40'h30_8000, 3, 0);
        n_cmp++;
        if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFF || resp_data !== e_data) begin
            n_bad++; $display("FAIL write_wins: got %h required ffffffffffffffff", resp_data);
        end
        consume(0);
        for (int c = 0; c < 4 * DIV && m_mtime != 0; c++) begin
            @(negedge clk);
            n_cmp++;
            if (timer_irq !== e_timer) begin
                n_bad++; $display("FAIL wrap_timer: got %b required %b", timer_irq, e_timer);
            end
        end
        issue(0, 40'h30_8000, 3, 0);
        n_cmp++;
        if (resp_data !== 64'd0 || resp_err !== 0) begin
            n_bad++; $display("FAIL mtime_wrap: got %h err=%b required 0/0", resp_data, resp_err);
        end
        consume(0);
    endtask

    task automatic test_err_hold;
        issue(0, 40'h30_4000 + 40'(8 * NC), 3, 0);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (resp_v !== 1 || resp_err !== 1 || resp_data !== 64'd0 || req_ready !== 0) begin
                n_bad++; $display("FAIL err_hold: got v=%b err=%b data=%h rdy=%b required 1/1/0/0", resp_v, resp_err, resp_data, req_ready);
            end
            @(negedge clk);
        end
        consume(0);
        issue(0, 40'h30_8004, 3, 0);
        n_cmp++;
        if (resp_err !== 1 || resp_data !== 64'd0) begin
            n_bad++; $display("FAIL misalign: got err=%b data=%h required 1/0", resp_err, resp_data);
        end
        consume(0);
    endtask

    task automatic test_half_and_reset;
        issue(1, 40'h30_4004, 2, 64'h0000_0000_DEAD_BEEF);
        consume(0);
        issue(0, 40'h30_4000, 3, 0);
        n_cmp++;
        if (resp_data !== 64'hDEAD_BEEF_FFFF_FFFF || resp_err !== 0) begin
            n_bad++; $display("FAIL half_write: got %h required deadbeefffffffff", resp_data);
        end
        rst_n = 0;
        @(negedge clk);
        n_cmp++;
        if (resp_v !== 0 || req_ready !== 1) begin
            n_bad++; $display("FAIL reset_in_resp: got v=%b rdy=%b required 0/1", resp_v, req_ready);
        end
        rst_n = 1;
        issue(0, 40'h30_4000, 3, 0);
        n_cmp++;
        if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++; $display("FAIL cmp_after_reset: got %h required ffffffffffffffff", resp_data);
        end
        consume(0);
    endtask

    task automatic test_random;
        logic [39:0] a;
        logic [63:0] d;
        logic [1:0]  sz;
        int          hold;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: a = 40'h30_0000 + 40'(8 * $urandom_range(0, NC));
                1: a = 40'h30_4000 + 40'(8 * $urandom_range(0, NC));
                2: a = 40'h30_8000;
                3: a = 40'h30_B000 + 40'(8 * $urandom_range(0, NC));
                4: a = 40'h30_0000 + 40'($urandom_range(0, 20'hF_FFF8));
                default: a = ($urandom_range(0, 1) != 0) ? 40'h70_8000 : 40'h01_0030_4000;
            endcase
            case ($urandom_range(0, 3))
                0: a = a + 40'($urandom_range(0, 7));
                1: a = a + 40'd4;
                default: ;
            endcase
            sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            d  = ($urandom_range(0, 1) != 0) ? m_mtime + 64'($urandom_range(0, 40)) : {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), a, sz, d);
            hold = $urandom_range(0, 2);
            for (int h = 0; h <= hold; h++) begin
                n_cmp++;
                if (resp_v !== 1 || req_ready !== 0 || resp_err !== e_err || resp_data !== e_data) begin
                    n_bad++; $display("FAIL rand_resp: addr=%h got v=%b rdy=%b err=%b data=%h required 1/0/%b/%h",
                                      a, resp_v, req_ready, resp_err, resp_data, e_err, e_data);
                end
                n_cmp++;
                if (soft_irq !== m_mipi || ext_irq !== m_plic || timer_irq !== e_timer) begin
                    n_bad++; $display("FAIL rand_irq: got s/t/e=%b/%b/%b required %b/%b/%b",
                                      soft_irq, timer_irq, ext_irq, m_mipi, e_timer, m_plic);
                end
                if (h < hold) begin
                    // a stray request while busy must be ignored
                    req_v = 1; req_we = 1; req_addr = 40'h30_8000; req_size = 3; req_data = '0;
                    @(negedge clk);
                    req_v = 0;
                end
            end
            consume(0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_idle_mtime();
        test_timer();
        test_soft_ext();
        test_write_over_tick();
        test_err_hold();
        test_half_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
